// File: rtl/pwm_duty_sched_pkg.sv
// Shared types and constants for the PWM duty scheduler: FSM state encoding,
// the default duty width and the key bit positions.
package pwm_sched_pkg;

    typedef enum logic [2:0] {
        MANUAL  = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } sched_state_t;

    localparam int DEF_DUTY_W = 10;

    localparam int KEY_UP = 0;
    localparam int KEY_DN = 1;

endpackage

// File: rtl/pwm_duty_sched_if.sv
// Control/observe bundle between the duty scheduler and its surroundings.
// duty_upd qualifies duty for exactly one cycle; there is no back-pressure.
interface pwm_duty_sched_if #(
    parameter int DUTY_W = pwm_sched_pkg::DEF_DUTY_W
);
    logic [1:0]        key;
    logic              mode;
    logic [DUTY_W-1:0] duty;
    logic              duty_upd;
    logic [2:0]        st;

    modport master (
        output key,
        output mode,
        input  duty,
        input  duty_upd,
        input  st
    );

    modport slave (
        input  key,
        input  mode,
        output duty,
        output duty_upd,
        output st
    );
endinterface

// File: rtl/pwm_duty_sched_key_debounce.sv
// One key bit: two-flop synchroniser followed by a stability counter. A new
// level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level
);
    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_level <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pwm_duty_sched.sv
// Duty-cycle scheduler for the LED PWM: manual ramping from debounced keys,
// or an automatic breathe cycle, with a strobe on every real duty change.
module pwm_duty_sched
    import pwm_sched_pkg::*;
#(
    parameter int DUTY_W     = DEF_DUTY_W,
    parameter int DEB_CYCLES = 50000,
    parameter int STEP_DIV   = 32768,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_duty_sched_if.slave    bus
);
    localparam int                TW         = $clog2(STEP_DIV + 1);
    localparam logic [TW-1:0]     TICK_LAST  = TW'(STEP_DIV - 1);
    localparam int                HW         = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [DUTY_W:0]   DUTY_MAX_E = {1'b0, {DUTY_W{1'b1}}};
    localparam logic [DUTY_W:0]   STEP_E     = (DUTY_W + 1)'(STEP);

    logic [1:0]        key_acc;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    sched_state_t      state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              upd_q;
    logic [DUTY_W:0]   sum_e, diff_e;
    logic [DUTY_W-1:0] duty_inc, duty_dec;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (bus.key[KEY_UP]),
        .key_level (key_acc[KEY_UP])
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (bus.key[KEY_DN]),
        .key_level (key_acc[KEY_DN])
    );

    assign tick = (tick_cnt == TICK_LAST);

    // One extra bit of headroom so the clamp sees overflow and borrow.
    always_comb begin
        sum_e    = {1'b0, duty_q} + STEP_E;
        diff_e   = {1'b0, duty_q} - STEP_E;
        duty_inc = (sum_e > DUTY_MAX_E) ? {DUTY_W{1'b1}} : sum_e[DUTY_W-1:0];
        duty_dec = diff_e[DUTY_W] ? '0 : diff_e[DUTY_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        unique case (state_q)
            MANUAL: begin
                hold_d = '0;
                if (bus.mode) begin
                    state_d = UP;
                end else if (tick) begin
                    unique case (key_acc)
                        2'b01:   duty_d = duty_inc;
                        2'b10:   duty_d = duty_dec;
                        default: duty_d = duty_q;
                    endcase
                end
            end
            UP: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    duty_d = duty_inc;
                    if (duty_inc == {DUTY_W{1'b1}}) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_HI: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            DOWN: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    duty_d = duty_dec;
                    if (duty_dec == '0) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_LO: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = MANUAL;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            state_q  <= MANUAL;
            hold_q   <= '0;
            duty_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            state_q  <= state_d;
            hold_q   <= hold_d;
            duty_q   <= duty_d;
            upd_q    <= (duty_d != duty_q);
        end
    end

    assign bus.duty     = duty_q;
    assign bus.duty_upd = upd_q;
    assign bus.st       = state_q;
endmodule

// File: tb/tb_pwm_duty_sched.sv
// Directed bench for pwm_duty_sched with small parameters: glitch rejection,
// manual ramp and clamps, full breathe cycle, mode drop on a tick, async reset.
module tb_pwm_duty_sched;
    import pwm_sched_pkg::*;

    localparam int DUTY_W     = 4;
    localparam int DEB_CYCLES = 4;
    localparam int STEP_DIV   = 8;
    localparam int STEP       = 3;
    localparam int HOLD_TICKS = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pwm_duty_sched_if #(.DUTY_W(DUTY_W)) bus ();

    pwm_duty_sched #(
        .DUTY_W     (DUTY_W),
        .DEB_CYCLES (DEB_CYCLES),
        .STEP_DIV   (STEP_DIV),
        .STEP       (STEP),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the next duty_upd, then checks value and spacing.
    task automatic wait_upd(input string tag, input int exp_duty, input int exp_gap);
        int n;
        n = 0;
        do begin
            step_clk(1);
            n++;
        end while (!bus.duty_upd && n < 40);
        check({tag, "_seen"}, 32'(bus.duty_upd), 32'd1);
        check({tag, "_duty"}, 32'(bus.duty), 32'(exp_duty));
        if (exp_gap >= 0) check({tag, "_gap"}, 32'(n), 32'(exp_gap));
    endtask

    task automatic expect_quiet(input string tag, input int n, input int exp_duty);
        int pulses;
        pulses = 0;
        repeat (n) begin
            step_clk(1);
            if (bus.duty_upd) pulses++;
        end
        check({tag, "_pulses"}, 32'(pulses), 32'd0);
        check({tag, "_duty"}, 32'(bus.duty), 32'(exp_duty));
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.key  = 2'b00;
        bus.mode = 1'b0;
        step_clk(3);
        check("rst_duty", 32'(bus.duty), 32'd0);
        check("rst_upd", 32'(bus.duty_upd), 32'd0);
        check("rst_st", 32'(bus.st), 32'(MANUAL));
        rst_n = 1'b1;

        // Three-cycle glitch on the up key must never be accepted.
        step_clk(2);
        bus.key = 2'b01;
        step_clk(3);
        bus.key = 2'b00;
        expect_quiet("glitch", 30, 0);

        // Manual up with saturation at 15.
        bus.key = 2'b01;
        wait_upd("up3", 3, -1);
        wait_upd("up6", 6, 8);
        wait_upd("up9", 9, 8);
        wait_upd("up12", 12, 8);
        wait_upd("up15", 15, 8);
        expect_quiet("sat_hi", 24, 15);
        bus.key = 2'b11;
        expect_quiet("both_keys", 30, 15);

        // Manual down; a step below zero clamps instead of wrapping to 13.
        bus.key = 2'b10;
        wait_upd("dn12", 12, -1);
        wait_upd("dn9", 9, 8);
        wait_upd("dn6", 6, 8);
        wait_upd("dn3", 3, 8);
        wait_upd("dn0", 0, 8);
        expect_quiet("sat_lo", 30, 0);
        check("manual_st", 32'(bus.st), 32'(MANUAL));
        bus.key = 2'b00;
        step_clk(10);

        // Breathe cycle with key activity that must be ignored.
        bus.mode = 1'b1;
        step_clk(1);
        check("br_enter_st", 32'(bus.st), 32'(UP));
        check("br_enter_duty", 32'(bus.duty), 32'd0);
        bus.key = 2'b01;
        wait_upd("br_u3", 3, -1);
        wait_upd("br_u6", 6, 8);
        bus.key = 2'b10;
        wait_upd("br_u9", 9, 8);
        wait_upd("br_u12", 12, 8);
        bus.key = 2'b11;
        wait_upd("br_u15", 15, 8);
        check("br_hold_hi_st", 32'(bus.st), 32'(HOLD_HI));
        wait_upd("br_d12", 12, 24);
        check("br_down_st", 32'(bus.st), 32'(DOWN));
        wait_upd("br_d9", 9, 8);
        wait_upd("br_d6", 6, 8);
        wait_upd("br_d3", 3, 8);
        wait_upd("br_d0", 0, 8);
        check("br_hold_lo_st", 32'(bus.st), 32'(HOLD_LO));
        wait_upd("br2_u3", 3, 24);
        check("br2_up_st", 32'(bus.st), 32'(UP));
        bus.key = 2'b00;
        wait_upd("br2_u6", 6, 8);
        wait_upd("br2_u9", 9, 8);
        wait_upd("br2_u12", 12, 8);
        wait_upd("br2_u15", 15, 8);
        wait_upd("br2_d12", 12, 24);
        wait_upd("br2_d9", 9, 8);

        // Drop mode exactly in the next tick cycle: no step, back to MANUAL.
        step_clk(7);
        check("pre_drop_st", 32'(bus.st), 32'(DOWN));
        bus.mode = 1'b0;
        step_clk(1);
        check("drop_st", 32'(bus.st), 32'(MANUAL));
        check("drop_duty", 32'(bus.duty), 32'd9);
        check("drop_upd", 32'(bus.duty_upd), 32'd0);
        expect_quiet("after_drop", 20, 9);

        // Bring duty to 6 manually, then enter UP.
        bus.key = 2'b10;
        wait_upd("man_dn6", 6, -1);
        bus.key = 2'b00;
        step_clk(2);
        bus.mode = 1'b1;
        step_clk(1);
        check("up6_st", 32'(bus.st), 32'(UP));
        check("up6_duty", 32'(bus.duty), 32'd6);

        // Asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_duty", 32'(bus.duty), 32'd0);
        check("arst_st", 32'(bus.st), 32'(MANUAL));
        check("arst_upd", 32'(bus.duty_upd), 32'd0);
        bus.mode = 1'b0;
        step_clk(2);
        rst_n = 1'b1;
        expect_quiet("post_rst", 20, 0);
        check("post_rst_st", 32'(bus.st), 32'(MANUAL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
